// File: rtl/wb_mem_pipe_pkg.sv
// Shared Wishbone constants: byte-lane width and SEL width derived from the data width.
package wb_mem_pipe_pkg;

  localparam int WB_LANE_W = 8;

  function automatic int wb_sel_w(input int dw);
    return dw / WB_LANE_W;
  endfunction

endpackage

// File: rtl/wb_mem_pipe_resp_pipe.sv
// Fixed-latency response line: {valid, is_read, data} shifted STAGES deep, flushable.
module wb_resp_pipe #(
  parameter int STAGES = 1,
  parameter int DW     = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic          o_rd,
  output logic [DW-1:0] o_data
);

  logic [STAGES-1:0]         vld_pipe_q;
  logic [STAGES-1:0]         rd_pipe_q;
  logic [STAGES-1:0][DW-1:0] data_pipe_q;

  // Only the control bits need clearing; stale data is masked by valid/is_read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      vld_pipe_q <= '0;
      rd_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0] <= i_vld;
      rd_pipe_q[0]  <= i_rd;
      for (int s = 1; s < STAGES; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        rd_pipe_q[s]  <= rd_pipe_q[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    data_pipe_q[0] <= i_data;
    for (int s = 1; s < STAGES; s++) data_pipe_q[s] <= data_pipe_q[s-1];
  end

  assign o_vld  = vld_pipe_q[STAGES-1];
  assign o_rd   = rd_pipe_q[STAGES-1];
  assign o_data = data_pipe_q[STAGES-1];

endmodule

// File: rtl/wb_mem_pipe.sv
// Wishbone B4 pipelined memory slave with configurable stall and ack wait states.
module wb_mem_pipe
  import wb_mem_pipe_pkg::*;
#(
  parameter int WB_ADDR_WIDTH   = 6,
  parameter int WB_DATA_WIDTH   = 32,
  parameter int STALL_WS        = 0,
  parameter int ACK_WS          = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_wb_cyc,
  input  logic                               i_wb_stb,
  input  logic                               i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0]           i_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0]           i_wb_data,
  input  logic [WB_DATA_WIDTH/WB_LANE_W-1:0] i_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]           o_wb_data,
  output logic                               o_wb_stall,
  output logic                               o_wb_ack
);

  localparam int DEPTH = 1 << WB_ADDR_WIDTH;
  localparam int SEL_W = wb_sel_w(WB_DATA_WIDTH);
  localparam int SCW   = (STALL_WS > 0) ? $clog2(STALL_WS + 1) : 1;
  localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);

  logic [WB_DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic                     accept, ack, rsp_rd;
  logic [WB_DATA_WIDTH-1:0] rd_data, rsp_in, rsp_data;
  logic [SCW-1:0]           stall_cnt_q, stall_cnt_d;
  logic [OCW-1:0]           outst_q, outst_d;

  assign o_wb_stall = !i_rst_n || (stall_cnt_q != '0) || (outst_q == OCW'(MAX_OUTSTANDING));
  assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;

  // Read data is captured at acceptance, before this edge's write lands.
  assign rd_data = mem_q[i_wb_addr];
  assign rsp_in  = (accept && !i_wb_we) ? rd_data : '0;

  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (i_wb_sel[b])
          mem_q[i_wb_addr][b*WB_LANE_W +: WB_LANE_W] <= i_wb_data[b*WB_LANE_W +: WB_LANE_W];
      end
    end
  end

  wb_resp_pipe #(
    .STAGES (ACK_WS + 1),
    .DW     (WB_DATA_WIDTH)
  ) u_resp (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (!i_wb_cyc),
    .i_vld   (accept),
    .i_rd    (!i_wb_we),
    .i_data  (rsp_in),
    .o_vld   (ack),
    .o_rd    (rsp_rd),
    .o_data  (rsp_data)
  );

  assign o_wb_ack  = ack;
  assign o_wb_data = (ack && rsp_rd) ? rsp_data : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    outst_d     = outst_q;
    if (!i_wb_cyc) begin
      stall_cnt_d = '0;
      outst_d     = '0;
    end else begin
      if (accept)                 stall_cnt_d = SCW'(STALL_WS);
      else if (stall_cnt_q != '0) stall_cnt_d = stall_cnt_q - SCW'(1);
      case ({accept, ack})
        2'b10:   outst_d = outst_q + OCW'(1);
        2'b01:   outst_d = outst_q - OCW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      outst_q     <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      outst_q     <= outst_d;
    end
  end

endmodule
